// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and data width for the uart_tx scheduler
package uart_tx_sched_pkg;
  localparam int UART_DW = 8;
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, WAIT, RELEASE, GAP} sched_state_e;
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester byte streams, uart_tx handshake and scheduler status
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*UART_DW-1:0] req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx_ready;
  logic                     tx_start;
  logic [UART_DW-1:0]       tx_data;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  logic                     pkt_cut;
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_start, tx_data, grant, busy, pkt_cut
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_start, tx_data, grant, busy, pkt_cut
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// uart_tx_sched_rr_arbiter: picks the first requester after ptr, wrapping around
module uart_tx_sched_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  logic          found;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin packet scheduler sharing one uart_tx among N_REQ requesters,
// with forced release on packet-length overrun or owner stall.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_PKT  = 16,
  parameter int STALL_TO = 1024,
  parameter int GAP_CYC  = 0
) (
  input logic            clk,
  input logic            rstn,
  uart_tx_sched_if.slave bus
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(STALL_TO + 1);
  localparam int DB = $clog2(UART_DW);
  sched_state_e   state;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx, ptr, gidx;
  logic [7:0]     byte_cnt, gap_cnt;
  logic [SW-1:0]  stall_cnt;
  logic           last_f;
  uart_tx_sched_rr_arbiter #(.N(N_REQ)) u_arb (
    .req(bus.req_valid), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= IW'(N_REQ - 1);
      gidx          <= '0;
      byte_cnt      <= '0;
      stall_cnt     <= '0;
      gap_cnt       <= '0;
      last_f        <= 1'b0;
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.grant     <= '0;
      bus.busy      <= 1'b0;
      bus.pkt_cut   <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.pkt_cut   <= 1'b0;
      case (state)
        IDLE: if (|bus.req_valid) begin
          bus.grant <= arb_gnt;
          gidx      <= arb_idx;
          byte_cnt  <= '0;
          stall_cnt <= '0;
          bus.busy  <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (bus.req_valid[gidx] && bus.tx_ready) begin
          bus.req_ready <= bus.grant;
          bus.tx_start  <= 1'b1;
          bus.tx_data   <= bus.req_data[{gidx, DB'(0)} +: UART_DW];
          byte_cnt      <= byte_cnt + 8'd1;
          last_f        <= bus.req_last[gidx];
          state         <= HOLD;
        end else if (!bus.req_valid[gidx]) begin
          if (stall_cnt == SW'(STALL_TO - 1)) begin
            bus.pkt_cut <= 1'b1;
            state       <= RELEASE;
          end else stall_cnt <= stall_cnt + 1'b1;
        end
        // uart_tx may take a cycle to drop tx_ready after tx_start
        HOLD: state <= WAIT;
        WAIT: if (bus.tx_ready) begin
          if (last_f) state <= RELEASE;
          else if (byte_cnt == 8'(MAX_PKT)) begin
            bus.pkt_cut <= 1'b1;
            state       <= RELEASE;
          end else begin
            stall_cnt <= '0;
            state     <= LOAD;
          end
        end
        RELEASE: begin
          ptr       <= gidx;
          bus.grant <= '0;
          gap_cnt   <= '0;
          bus.busy  <= GAP_CYC > 0;
          state     <= GAP_CYC > 0 ? GAP : IDLE;
        end
        GAP: if (gap_cnt == 8'(GAP_CYC - 1)) begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end else gap_cnt <= gap_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of uart_tx_sched against a small uart_tx and requester model
module tb_uart_tx_sched;
  localparam int FRAME = 5;
  logic clk = 1'b0;
  logic rstn;
  logic tx_hold;
  int   n_run = 0, n_fail = 0;
  logic [8:0] mem [4][32];
  int   head [4] = '{0, 0, 0, 0};
  int   tail [4] = '{0, 0, 0, 0};
  int   bcnt = 0;
  logic [7:0] log_data [64];
  logic [3:0] log_grant [64];
  int   nlog = 0, cut_cnt = 0, bad_cnt = 0;
  int   base, c0, n, s_cnt, r_cnt, p_cnt;

  uart_tx_sched_if #(.N_REQ(4)) bus ();
  uart_tx_sched #(.N_REQ(4), .MAX_PKT(4), .STALL_TO(8), .GAP_CYC(0)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]       = head[i] != tail[i];
      bus.req_last[i]        = mem[i][head[i]][8];
      bus.req_data[i*8 +: 8] = mem[i][head[i]][7:0];
    end
  end

  assign bus.tx_ready = (bcnt == 0) && !tx_hold;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) head[i] <= head[i] + 1;
    if (bus.tx_start) bcnt <= FRAME;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  always @(negedge clk) begin
    if (bus.tx_start) begin
      log_data[nlog]  <= bus.tx_data;
      log_grant[nlog] <= bus.grant;
      nlog            <= nlog + 1;
    end
    if (bus.pkt_cut) cut_cnt <= cut_cnt + 1;
    if ((bus.req_ready & ~bus.grant) != 0 || $countones(bus.req_ready) > 1 ||
        bus.tx_start != (bus.req_ready != 0)) bad_cnt <= bad_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic chk_tx(input string tag, input int k, input logic [7:0] d, input logic [3:0] g);
    chk({tag, "_data"}, 32'(log_data[k]), 32'(d));
    chk({tag, "_grant"}, 32'(log_grant[k]), 32'(g));
  endtask

  task automatic drain(input string tag);
    int  c = 0;
    logic done = 1'b0;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
      done = (head[0] == tail[0]) && (head[1] == tail[1]) && (head[2] == tail[2]) &&
             (head[3] == tail[3]) && !bus.busy && bcnt == 0;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    rstn    = 1'b0;
    tx_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_pkt_cut", 32'(bus.pkt_cut), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    rstn = 1'b1;
    // contention from the reset pointer: requester 0 wins, then requester 2
    base = nlog;
    push(0, 8'hB0, 0); push(0, 8'hB1, 1); push(2, 8'hC0, 0); push(2, 8'hC1, 1);
    drain("t2a");
    chk("t2a_n", 32'(nlog - base), 4);
    chk_tx("t2a_0", base, 8'hB0, 4'b0001);
    chk_tx("t2a_1", base + 1, 8'hB1, 4'b0001);
    chk_tx("t2a_2", base + 2, 8'hC0, 4'b0100);
    chk_tx("t2a_3", base + 3, 8'hC1, 4'b0100);
    // last owner was 2, so 0 still precedes 2
    base = nlog;
    push(0, 8'hB2, 0); push(0, 8'hB3, 1); push(2, 8'hC2, 0); push(2, 8'hC3, 1);
    drain("t2b");
    chk_tx("t2b_0", base, 8'hB2, 4'b0001);
    chk_tx("t2b_2", base + 2, 8'hC2, 4'b0100);
    chk_tx("t2b_3", base + 3, 8'hC3, 4'b0100);
    // single requester, 3-byte packet
    base = nlog;
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    drain("t1");
    chk("t1_n", 32'(nlog - base), 3);
    chk_tx("t1_0", base, 8'hA1, 4'b0001);
    chk_tx("t1_1", base + 1, 8'hA2, 4'b0001);
    chk_tx("t1_2", base + 2, 8'hA3, 4'b0001);
    chk("t1_grant_end", 32'(bus.grant), 0);
    chk("t1_busy_end", 32'(bus.busy), 0);
    // requester 0 was last owner: 2 now goes first
    base = nlog;
    push(0, 8'hB4, 0); push(0, 8'hB5, 1); push(2, 8'hC4, 0); push(2, 8'hC5, 1);
    drain("t2c");
    chk_tx("t2c_0", base, 8'hC4, 4'b0100);
    chk_tx("t2c_2", base + 2, 8'hB4, 4'b0001);
    chk_tx("t2c_3", base + 3, 8'hB5, 4'b0001);
    // MAX_PKT cut of requester 1, pending requester 3 served before the remainder
    base = nlog; c0 = cut_cnt;
    for (int i = 0; i < 6; i++) push(1, 8'hD0 + 8'(i), i == 5);
    push(3, 8'hE0, 0); push(3, 8'hE1, 1);
    drain("t3");
    chk("t3_n", 32'(nlog - base), 8);
    chk_tx("t3_3", base + 3, 8'hD3, 4'b0010);
    chk_tx("t3_4", base + 4, 8'hE0, 4'b1000);
    chk_tx("t3_5", base + 5, 8'hE1, 4'b1000);
    chk_tx("t3_6", base + 6, 8'hD4, 4'b0010);
    chk_tx("t3_7", base + 7, 8'hD5, 4'b0010);
    chk("t3_cuts", 32'(cut_cnt - c0), 1);
    // last byte coinciding with MAX_PKT is a normal release
    base = nlog; c0 = cut_cnt;
    for (int i = 0; i < 4; i++) push(2, 8'h90 + 8'(i), i == 3);
    drain("t3b");
    chk("t3b_n", 32'(nlog - base), 4);
    chk("t3b_cuts", 32'(cut_cnt - c0), 0);
    // owner stalls after one byte
    c0 = cut_cnt;
    push(0, 8'hF0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tx_start && n < 50);
    chk("t4_start", 32'(bus.tx_start), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.pkt_cut && n < 50);
    chk("t4_cut_delay", 32'(n), 15);
    @(negedge clk);
    chk("t4_grant", 32'(bus.grant), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    drain("t4");
    chk("t4_cuts", 32'(cut_cnt - c0), 1);
    // reset while the owner waits on the uart frame
    base = nlog;
    push(0, 8'h70, 0); push(0, 8'h71, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tx_start && n < 50);
    chk("t6_first", 32'(bus.tx_data), 32'h70);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_grant", 32'(bus.grant), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_tx_data", 32'(bus.tx_data), 0);
    chk("t6_tx_start", 32'(bus.tx_start), 0);
    chk("t6_req_ready", 32'(bus.req_ready), 0);
    rstn = 1'b1;
    push(1, 8'h81, 1);
    drain("t6");
    chk("t6_n", 32'(nlog - base), 3);
    chk_tx("t6_1", base + 1, 8'h71, 4'b0001);
    chk_tx("t6_2", base + 2, 8'h81, 4'b0010);
    // uart held busy: nothing may launch, no stall release
    tx_hold = 1'b1;
    push(1, 8'h5A, 1);
    s_cnt = 0; r_cnt = 0; p_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      s_cnt += int'(bus.tx_start);
      r_cnt += int'(bus.req_ready != 0);
      p_cnt += int'(bus.pkt_cut);
    end
    chk("t5_no_start", 32'(s_cnt), 0);
    chk("t5_no_ready", 32'(r_cnt), 0);
    chk("t5_no_cut", 32'(p_cnt), 0);
    chk("t5_grant_hold", 32'(bus.grant), 32'b0010);
    tx_hold = 1'b0;
    @(negedge clk);
    chk("t5_start", 32'(bus.tx_start), 1);
    chk("t5_data", 32'(bus.tx_data), 32'h5A);
    chk("t5_req_ready", 32'(bus.req_ready), 32'b0010);
    drain("t5");
    chk("handshake_invariants", 32'(bad_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
